// File: rtl/adc_spi_capture.sv
// Paces conversions of a 16-bit serial ADC: CONVST pulse, conversion wait, 16-bit MSB-first
// read over SCLK/CS_N, then a one-cycle adc_data_valid strobe with the captured word.
module adc_spi_capture #(
  parameter int SAMPLE_PERIOD = 100,
  parameter int CONVST_CYCLES = 4,
  parameter int CONV_WAIT     = 10,
  parameter int CLK_DIV       = 2
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        enable,
  input  logic        adc_bypass,
  input  logic        clear_overrun,
  input  logic        adc_sdo,
  output logic        adc_convst,
  output logic        adc_cs_n,
  output logic        adc_sclk,
  output logic [15:0] adc_data,
  output logic        adc_data_valid,
  output logic        sample_overrun,
  output logic [31:0] sample_count,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CONVST = 3'd1,
    S_WAIT   = 3'd2,
    S_SHIFT  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] per_cnt_q, per_cnt_d;
  logic [31:0] st_cnt_q, st_cnt_d;
  logic [31:0] div_cnt_q, div_cnt_d;
  logic        high_q, high_d;
  logic [3:0]  bit_cnt_q, bit_cnt_d;
  logic [15:0] shreg_q, shreg_d;
  logic [15:0] data_q, data_d;
  logic        valid_q, valid_d;
  logic        overrun_q, overrun_d;
  logic [31:0] count_q, count_d;
  logic        tick;
  logic        start;

  always_comb begin
    state_d   = state_q;
    per_cnt_d = per_cnt_q;
    st_cnt_d  = st_cnt_q;
    div_cnt_d = div_cnt_q;
    high_d    = high_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    data_d    = data_q;
    valid_d   = 1'b0;
    overrun_d = overrun_q;
    count_d   = count_q;

    tick  = enable && (per_cnt_q == 32'(SAMPLE_PERIOD - 1));
    start = tick && !adc_bypass;

    if (!enable || tick) per_cnt_d = 32'd0;
    else                 per_cnt_d = per_cnt_q + 32'd1;

    // A start request while a conversion is in flight is dropped and flagged; set beats clear.
    if (start && (state_q != S_IDLE)) overrun_d = 1'b1;
    else if (clear_overrun)           overrun_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_CONVST;
          st_cnt_d = 32'd0;
        end
      end
      S_CONVST: begin
        if (st_cnt_q == 32'(CONVST_CYCLES - 1)) begin
          state_d  = S_WAIT;
          st_cnt_d = 32'd0;
        end else begin
          st_cnt_d = st_cnt_q + 32'd1;
        end
      end
      S_WAIT: begin
        if (st_cnt_q == 32'(CONV_WAIT - 1)) begin
          state_d   = S_SHIFT;
          st_cnt_d  = 32'd0;
          div_cnt_d = 32'd0;
          high_d    = 1'b0;
          bit_cnt_d = 4'd0;
        end else begin
          st_cnt_d = st_cnt_q + 32'd1;
        end
      end
      S_SHIFT: begin
        if (div_cnt_q == 32'(CLK_DIV - 1)) begin
          div_cnt_d = 32'd0;
          if (!high_q) begin
            // This edge drives SCLK 0->1, so it is the capture point for the current bit.
            high_d  = 1'b1;
            shreg_d = {shreg_q[14:0], adc_sdo};
          end else begin
            high_d = 1'b0;
            if (bit_cnt_q == 4'd15) state_d = S_DONE;
            else                    bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end else begin
          div_cnt_d = div_cnt_q + 32'd1;
        end
      end
      S_DONE: begin
        data_d  = shreg_q;
        valid_d = 1'b1;
        count_d = count_q + 32'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= S_IDLE;
      per_cnt_q <= 32'd0;
      st_cnt_q  <= 32'd0;
      div_cnt_q <= 32'd0;
      high_q    <= 1'b0;
      bit_cnt_q <= 4'd0;
      shreg_q   <= 16'd0;
      data_q    <= 16'd0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
      count_q   <= 32'd0;
    end else begin
      state_q   <= state_d;
      per_cnt_q <= per_cnt_d;
      st_cnt_q  <= st_cnt_d;
      div_cnt_q <= div_cnt_d;
      high_q    <= high_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
      count_q   <= count_d;
    end
  end

  assign adc_convst     = (state_q == S_CONVST);
  assign adc_cs_n       = (state_q != S_SHIFT);
  assign adc_sclk       = (state_q == S_SHIFT) && high_q;
  assign adc_data       = data_q;
  assign adc_data_valid = valid_q;
  assign sample_overrun = overrun_q;
  assign sample_count   = count_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_adc_spi_capture.sv
// Bench for adc_spi_capture: default instance with a serial ADC model plus a short-period
// instance for overrun behaviour. Words issued to the ADC model are queued as expected results.
module tb_adc_spi_capture;

  // Handshake: adc_data_valid is a one-cycle strobe; adc_data is only meaningful while it is high.

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rstn = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT A (defaults) ----------------
  logic        en_a = 1'b0, byp_a = 1'b0, clr_a = 1'b0;
  logic        adc_sdo;
  logic        convst_a, csn_a, sclk_a, valid_a, ovr_a;
  logic [15:0] data_a;
  logic [31:0] cnt_a;
  logic [2:0]  dbg_a;

  adc_spi_capture dut_a (
    .clk(clk), .rstn(rstn), .enable(en_a), .adc_bypass(byp_a), .clear_overrun(clr_a),
    .adc_sdo(adc_sdo), .adc_convst(convst_a), .adc_cs_n(csn_a), .adc_sclk(sclk_a),
    .adc_data(data_a), .adc_data_valid(valid_a), .sample_overrun(ovr_a),
    .sample_count(cnt_a), .dbg_state(dbg_a)
  );

  // ---------------- DUT B (SAMPLE_PERIOD=50, SDO tied high) ----------------
  logic        en_b = 1'b0, clr_b = 1'b0;
  logic        sdo_b = 1'b1;
  logic        convst_b, csn_b, sclk_b, valid_b, ovr_b;
  logic [15:0] data_b;
  logic [31:0] cnt_b;
  logic [2:0]  dbg_b;

  adc_spi_capture #(.SAMPLE_PERIOD(50)) dut_b (
    .clk(clk), .rstn(rstn), .enable(en_b), .adc_bypass(1'b0), .clear_overrun(clr_b),
    .adc_sdo(sdo_b), .adc_convst(convst_b), .adc_cs_n(csn_b), .adc_sclk(sclk_b),
    .adc_data(data_b), .adc_data_valid(valid_b), .sample_overrun(ovr_b),
    .sample_count(cnt_b), .dbg_state(dbg_b)
  );

  // ---------------- checking infrastructure ----------------
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_q[$];
  int          exp_t_q[$];
  logic [15:0] adc_word_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- ADC model ----------------
  logic [15:0] adc_sh = 16'd0;
  always @(negedge csn_a or posedge sclk_a) begin
    if (!sclk_a) adc_sh = (adc_word_q.size() != 0) ? adc_word_q.pop_front() : 16'd0;
    else         adc_sh = {adc_sh[14:0], 1'b0};
  end
  assign adc_sdo = adc_sh[15];

  // ---------------- driver tasks ----------------
  task automatic wait_until(input int n);
    while (cyc < n) @(negedge clk);
  endtask

  task automatic issue(input logic [15:0] w, input int t);
    adc_word_q.push_back(w);
    exp_q.push_back(w);
    exp_t_q.push_back(t);
  endtask

  // ---------------- scoreboard / protocol monitor for DUT A ----------------
  logic [31:0] exp_cnt = 32'd0;
  logic        prev_valid = 1'b0, prev_sclk = 1'b0, prev_convst = 1'b0;
  logic        in_frame = 1'b0;
  int          rises = 0, run = 0, bad_run = 0, viol = 0, convst_rises = 0, vb_total = 0;

  always @(negedge clk) begin
    if (!rstn) begin
      exp_cnt  = 32'd0;
      in_frame = 1'b0;
      prev_valid = 1'b0;
      prev_sclk  = 1'b0;
      prev_convst = 1'b0;
    end else begin
      if (valid_a) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_valid: got data 0x%04h with no expected word (cycle %0d)", data_a, cyc);
        end else begin
          logic [15:0] w;
          int t;
          w = exp_q.pop_front();
          t = exp_t_q.pop_front();
          exp_cnt = exp_cnt + 32'd1;
          chk("adc_data", {16'd0, data_a}, {16'd0, w});
          chk("valid_cycle", 32'(cyc), 32'(t));
          chk("sample_count", cnt_a, exp_cnt);
        end
      end
      if (valid_a && prev_valid) viol++;
      if (convst_a && !csn_a)    viol++;
      if (sclk_a && csn_a)       viol++;
      if (convst_a && !prev_convst) convst_rises++;

      if (!csn_a) begin
        if (!in_frame) begin
          in_frame = 1'b1;
          rises = 0;
          run = 0;
          bad_run = 0;
        end
        if (sclk_a && !prev_sclk) rises++;
        if (sclk_a) run++;
        if (!sclk_a && prev_sclk) begin
          if (run != 2) bad_run++;
          run = 0;
        end
      end else if (in_frame) begin
        in_frame = 1'b0;
        chk("frame_sclk_rises", 32'(rises), 32'd16);
        chk("frame_sclk_high_len_errs", 32'(bad_run), 32'd0);
      end
      prev_valid  = valid_a;
      prev_sclk   = sclk_a;
      prev_convst = convst_a;
    end
    if (valid_b) vb_total++;
  end

  // ---------------- stimulus ----------------
  int e, eb, cr0, r;

  initial begin
    // reset values
    wait_until(2);
    chk("rst_convst", {31'd0, convst_a}, 32'd0);
    chk("rst_cs_n",   {31'd0, csn_a},    32'd1);
    chk("rst_sclk",   {31'd0, sclk_a},   32'd0);
    chk("rst_data",   {16'd0, data_a},   32'd0);
    chk("rst_valid",  {31'd0, valid_a},  32'd0);
    chk("rst_overrun",{31'd0, ovr_a},    32'd0);
    chk("rst_count",  cnt_a,             32'd0);
    chk("rst_state",  {29'd0, dbg_a},    32'd0);
    wait_until(3);
    rstn = 1'b1;

    // overrun with SAMPLE_PERIOD=50: ticks at eb+49/99/149/199
    wait_until(5);
    eb = cyc;
    en_b = 1'b1;
    wait_until(eb + 99);
    chk("b_ovr_before_tick2", {31'd0, ovr_b}, 32'd0);
    wait_until(eb + 100);
    chk("b_ovr_after_tick2", {31'd0, ovr_b}, 32'd1);
    wait_until(eb + 120);
    clr_b = 1'b1;
    wait_until(eb + 121);
    clr_b = 1'b0;
    chk("b_ovr_cleared", {31'd0, ovr_b}, 32'd0);
    wait_until(eb + 129);
    chk("b_valid1", {31'd0, valid_b}, 32'd1);
    chk("b_data1", {16'd0, data_b}, 32'h0000_FFFF);
    chk("b_count1", cnt_b, 32'd1);
    wait_until(eb + 199);
    clr_b = 1'b1;
    wait_until(eb + 200);
    clr_b = 1'b0;
    chk("b_set_beats_clear", {31'd0, ovr_b}, 32'd1);
    wait_until(eb + 229);
    chk("b_valid2", {31'd0, valid_b}, 32'd1);
    chk("b_count2", cnt_b, 32'd2);
    wait_until(eb + 240);
    en_b = 1'b0;
    chk("b_valids_every_other_tick", 32'(vb_total), 32'd2);

    // two samples 100 cycles apart, first 80 cycles after the first tick
    wait_until(300);
    e = cyc;
    issue(16'h0100, e + 179);
    issue(16'hA5C3, e + 279);
    en_a = 1'b1;
    wait_until(e + 285);
    en_a = 1'b0;
    chk("a_count_after_two", cnt_a, 32'd2);

    // bit order
    wait_until(600);
    e = cyc;
    issue(16'h8001, e + 179);
    en_a = 1'b1;
    wait_until(e + 185);
    en_a = 1'b0;

    // bypass for five periods, then release
    wait_until(900);
    e = cyc;
    cr0 = convst_rises;
    byp_a = 1'b1;
    en_a = 1'b1;
    wait_until(e + 505);
    chk("bypass_no_convst", 32'(convst_rises), 32'(cr0));
    chk("bypass_no_overrun", {31'd0, ovr_a}, 32'd0);
    byp_a = 1'b0;
    issue(16'h3C5A, e + 679);
    wait_until(e + 685);
    en_a = 1'b0;
    chk("bypass_release_convst", 32'(convst_rises), 32'(cr0 + 1));

    // enable dropped one cycle after CONVST entry
    wait_until(1600);
    e = cyc;
    cr0 = convst_rises;
    issue(16'h1234, e + 179);
    en_a = 1'b1;
    wait_until(e + 100);
    chk("convst_entry_state", {29'd0, dbg_a}, 32'd1);
    wait_until(e + 101);
    en_a = 1'b0;
    wait_until(e + 679);
    chk("no_starts_after_disable", 32'(convst_rises), 32'(cr0 + 1));

    // reset during SHIFT at bit 8
    wait_until(2300);
    e = cyc;
    adc_word_q.push_back(16'hFFFF);
    en_a = 1'b1;
    wait_until(e + 146);
    chk("pre_reset_shift_state", {29'd0, dbg_a}, 32'd3);
    rstn = 1'b0;
    #1;
    chk("abort_cs_n",  {31'd0, csn_a},   32'd1);
    chk("abort_sclk",  {31'd0, sclk_a},  32'd0);
    chk("abort_data",  {16'd0, data_a},  32'd0);
    chk("abort_valid", {31'd0, valid_a}, 32'd0);
    chk("abort_count", cnt_a,            32'd0);
    wait_until(e + 150);
    r = cyc;
    rstn = 1'b1;
    issue(16'h5AA5, r + 179);
    wait_until(r + 185);
    en_a = 1'b0;
    chk("count_after_reset", cnt_a, 32'd1);

    wait_until(r + 200);
    chk("pending_expected", 32'(exp_q.size()), 32'd0);
    chk("protocol_violations", 32'(viol), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
